ram_rw_ctl: RTL



---
 rtl/ram_rw_pkg.sv | 30 +++
 rtl/ram_rw_ctl_rx_timeout.sv | 35 +++
 rtl/ram_rw_ctl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_rw_pkg.sv
// Shared types for the UART debug loader: opcodes, reply bytes and controller states.
package ram_rw_pkg;

   typedef enum logic [7:0] {
      CmdCpuRst = 8'h2A,
      CmdCpuRun = 8'h2B,
      CmdConfWr = 8'h2C,
      CmdConfRd = 8'h2D,
      CmdDataWr = 8'h2E,
      CmdDataRd = 8'h2F
   } cmd_t;

   localparam logic [7:0] ReplyAck = 8'h06;
   localparam logic [7:0] ReplyNak = 8'h15;

   typedef enum logic [3:0] {
      StCmd,
      StCfgWr,
      StCfgRd,
      StWrData,
      StWrMem,
      StRdReq,
      StRdWait,
      StRdSend,
      StCkRx,
      StCkTx,
      StReply
   } state_t;

endpackage

// File: rtl/ram_rw_ctl_rx_timeout.sv
// Receive watchdog: reloads to Cycles on clear, counts down while enabled, flags at zero.
module rx_timeout #(
   parameter int unsigned Cycles = 1000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CntW = $clog2(Cycles + 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = CntW'(Cycles);
      end else if (en_i && cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= CntW'(Cycles);
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = en_i & (cnt_q == '0);

endmodule

// File: rtl/ram_rw_ctl.sv
// UART debug loader giving a host word-wide RAM access while the CPU is held in reset.
// Optional RAM_RW_CKSUM_EN adds an XOR checksum byte after DATA_WR / DATA_RD payloads.
module ram_rw_ctl
   import ram_rw_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned WORD_BYTES  = 4,
   parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [7:0]              rx_data_i,
   input  logic                    rx_vld_i,
   output logic                    rx_rdy_o,
   output logic [7:0]              tx_data_o,
   output logic                    tx_vld_o,
   input  logic                    tx_rdy_i,
   output logic                    mem_req_o,
   output logic                    mem_we_o,
   output logic [XLEN-1:0]         mem_addr_o,
   output logic [WORD_BYTES-1:0]   mem_be_o,
   output logic [8*WORD_BYTES-1:0] mem_wdata_o,
   input  logic [8*WORD_BYTES-1:0] mem_rdata_i,
   output logic                    cpu_rst_n_o
);

   localparam int unsigned WordW    = 8 * WORD_BYTES;
   localparam int unsigned LaneW    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam int unsigned CfgBytes = 2 * XLEN / 8;
   localparam logic [XLEN-1:0]  LaneMask = XLEN'(WORD_BYTES - 1);
   localparam logic [LaneW-1:0] TopLane  = LaneW'(WORD_BYTES - 1);

   state_t              state_q, state_d;
   logic [XLEN-1:0]     addr_q, addr_d;
   logic [XLEN-1:0]     len_q, len_d;
   logic [XLEN-1:0]     cnt_q, cnt_d;
   logic                last_q, last_d;
   logic                cpu_rst_n_q, cpu_rst_n_d;
   logic                rx_rdy_q, rx_rdy_d;
   logic [WordW-1:0]    wbuf_q, wbuf_d;
   logic [WORD_BYTES-1:0] be_q, be_d;
   logic [XLEN-1:0]     waddr_q, waddr_d;
   logic [WordW-1:0]    rdata_q, rdata_d;
   logic [2*XLEN-1:0]   cfg_sr_q, cfg_sr_d;
   logic [7:0]          reply_q, reply_d;
`ifdef RAM_RW_CKSUM_EN
   logic [7:0]          cksum_q, cksum_d;
`endif

   logic            rx_fire, tx_fire;
   logic [XLEN-1:0] cur, cur_word;
   logic [LaneW-1:0] lane;
   logic            tmo_en, tmo_clr, tmo_expired;

   assign rx_fire  = rx_vld_i & rx_rdy_o;
   assign tx_fire  = tx_vld_o & tx_rdy_i;
   assign cur      = addr_q + cnt_q;
   assign cur_word = cur & ~LaneMask;
   assign lane     = LaneW'(cur & LaneMask);

   assign tmo_en  = state_q inside {StCfgWr, StWrData, StCkRx};
   assign tmo_clr = ~tmo_en | rx_fire;

   rx_timeout #(
      .Cycles(TIMEOUT_CYC)
   ) u_rx_timeout (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (tmo_clr),
      .en_i     (tmo_en),
      .expired_o(tmo_expired)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      cpu_rst_n_d = cpu_rst_n_q;
      wbuf_d      = wbuf_q;
      be_d        = be_q;
      waddr_d     = waddr_q;
      rdata_d     = rdata_q;
      cfg_sr_d    = cfg_sr_q;
      reply_d     = reply_q;
`ifdef RAM_RW_CKSUM_EN
      cksum_d     = cksum_q;
`endif

      unique case (state_q)
         StCmd: begin
            if (rx_fire) begin
               cnt_d       = '0;
               cpu_rst_n_d = 1'b0;
`ifdef RAM_RW_CKSUM_EN
               cksum_d     = '0;
`endif
               case (rx_data_i)
                  CmdCpuRst: begin
                     reply_d = ReplyAck;
                     state_d = StReply;
                  end
                  CmdCpuRun: begin
                     cpu_rst_n_d = 1'b1;
                     reply_d     = ReplyAck;
                     state_d     = StReply;
                  end
                  CmdConfWr: state_d = StCfgWr;
                  CmdConfRd: begin
                     cfg_sr_d = {len_q, addr_q};
                     state_d  = StCfgRd;
                  end
                  CmdDataWr: begin
                     wbuf_d  = '0;
                     be_d    = '0;
                     state_d = StWrData;
                  end
                  CmdDataRd: state_d = StRdReq;
                  default: begin
                     cpu_rst_n_d = cpu_rst_n_q;
                     reply_d     = ReplyNak;
                     state_d     = StReply;
                  end
               endcase
            end
         end

         StCfgWr: begin
            if (rx_fire) begin
               // Shadow image commits only once complete, so a timeout leaves addr/len intact.
               cfg_sr_d = {rx_data_i, cfg_sr_q[2*XLEN-1:8]};
               cnt_d    = cnt_q + 1'b1;
               if (cnt_q == XLEN'(CfgBytes - 1)) begin
                  addr_d  = cfg_sr_d[XLEN-1:0];
                  len_d   = cfg_sr_d[2*XLEN-1:XLEN];
                  reply_d = ReplyAck;
                  state_d = StReply;
               end
            end else if (tmo_expired) begin
               reply_d = ReplyNak;
               state_d = StReply;
            end
         end

         StCfgRd: begin
            if (tx_fire) begin
               cfg_sr_d = cfg_sr_q >> 8;
               cnt_d    = cnt_q + 1'b1;
               if (cnt_q == XLEN'(CfgBytes - 1)) begin
                  reply_d = ReplyAck;
                  state_d = StReply;
               end
            end
         end

         StWrData: begin
            if (rx_fire) begin
               wbuf_d[8*lane +: 8] = rx_data_i;
               be_d[lane]          = 1'b1;
               waddr_d             = cur_word;
               last_d              = (cnt_q == len_q);
               cnt_d               = cnt_q + 1'b1;
`ifdef RAM_RW_CKSUM_EN
               cksum_d             = cksum_q ^ rx_data_i;
`endif
               if (lane == TopLane || cnt_q == len_q) begin
                  state_d = StWrMem;
               end
            end else if (tmo_expired) begin
               be_d    = '0;
               reply_d = ReplyNak;
               state_d = StReply;
            end
         end

         StWrMem: begin
            wbuf_d = '0;
            be_d   = '0;
            if (last_q) begin
`ifdef RAM_RW_CKSUM_EN
               state_d = StCkRx;
`else
               reply_d = ReplyAck;
               state_d = StReply;
`endif
            end else begin
               state_d = StWrData;
            end
         end

         StRdReq:  state_d = StRdWait;

         StRdWait: begin
            rdata_d = mem_rdata_i;
            state_d = StRdSend;
         end

         StRdSend: begin
            if (tx_fire) begin
`ifdef RAM_RW_CKSUM_EN
               cksum_d = cksum_q ^ tx_data_o;
`endif
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == len_q) begin
`ifdef RAM_RW_CKSUM_EN
                  state_d = StCkTx;
`else
                  reply_d = ReplyAck;
                  state_d = StReply;
`endif
               end else if (lane == TopLane) begin
                  state_d = StRdReq;
               end
            end
         end

`ifdef RAM_RW_CKSUM_EN
         StCkRx: begin
            if (rx_fire) begin
               reply_d = (rx_data_i == cksum_q) ? ReplyAck : ReplyNak;
               state_d = StReply;
            end else if (tmo_expired) begin
               reply_d = ReplyNak;
               state_d = StReply;
            end
         end

         StCkTx: begin
            if (tx_fire) begin
               reply_d = ReplyAck;
               state_d = StReply;
            end
         end
`endif

         StReply: begin
            if (tx_fire) begin
               state_d = StCmd;
            end
         end

         default: state_d = StCmd;
      endcase
   end

   assign rx_rdy_d = state_d inside {StCmd, StCfgWr, StWrData, StCkRx};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StCmd;
         addr_q      <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         last_q      <= 1'b0;
         cpu_rst_n_q <= 1'b0;
         rx_rdy_q    <= 1'b0;
         wbuf_q      <= '0;
         be_q        <= '0;
         waddr_q     <= '0;
         rdata_q     <= '0;
         cfg_sr_q    <= '0;
         reply_q     <= '0;
`ifdef RAM_RW_CKSUM_EN
         cksum_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         cpu_rst_n_q <= cpu_rst_n_d;
         rx_rdy_q    <= rx_rdy_d;
         wbuf_q      <= wbuf_d;
         be_q        <= be_d;
         waddr_q     <= waddr_d;
         rdata_q     <= rdata_d;
         cfg_sr_q    <= cfg_sr_d;
         reply_q     <= reply_d;
`ifdef RAM_RW_CKSUM_EN
         cksum_q     <= cksum_d;
`endif
      end
   end

   // Strobes are gated by reset so an abort never issues a RAM write or a reply.
   assign rx_rdy_o    = rx_rdy_q;
   assign cpu_rst_n_o = cpu_rst_n_q;
   assign tx_vld_o    = ~rst_i & (state_q inside {StCfgRd, StRdSend, StCkTx, StReply});
   assign mem_req_o   = ~rst_i & (state_q inside {StWrMem, StRdReq});
   assign mem_we_o    = ~rst_i & (state_q == StWrMem);
   assign mem_addr_o  = (state_q == StWrMem) ? waddr_q :
                        (state_q == StRdReq) ? cur_word : '0;
   assign mem_be_o    = (state_q == StWrMem) ? be_q :
                        (state_q == StRdReq) ? '1 : '0;
   assign mem_wdata_o = (state_q == StWrMem) ? wbuf_q : '0;

   always_comb begin
      tx_data_o = '0;
      unique case (state_q)
         StCfgRd:  tx_data_o = cfg_sr_q[7:0];
         StRdSend: tx_data_o = rdata_q[8*lane +: 8];
`ifdef RAM_RW_CKSUM_EN
         StCkTx:   tx_data_o = cksum_q;
`endif
         StReply:  tx_data_o = reply_q;
         default:  tx_data_o = '0;
      endcase
   end

endmodule
